// File: rtl/fft_delay_ctrl_pkg.sv
// Shared types and helpers for the 4-point SDF FFT sequencer.
package fft_delay_ctrl_pkg;

  localparam int unsigned DNUM_W = 2;

  typedef enum logic [1:0] {
    FFT_IDLE  = 2'd0,
    FFT_CFG   = 2'd1,
    FFT_RUN   = 2'd2,
    FFT_FLUSH = 2'd3
  } fft_state_e;

  // Reverse the low w bits of v (w <= 8).
  function automatic logic [7:0] bit_rev(input logic [7:0] v, input int unsigned w);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) begin
      r[3'(i)] = v[3'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_delay_ctrl_if.sv
// Host handshake, sample framing and stage control bundle.
// Optional frames_done counter port when FFT_DELAY_CTRL_STAT_EN is defined.
interface fft_delay_ctrl_if
  import fft_delay_ctrl_pkg::*;
#(
  parameter int unsigned LOG2N   = 2,
  parameter int unsigned FRAME_W = 8
);

  logic                 start;
  logic [FRAME_W-1:0]   frames;
  logic                 in_valid;
  logic                 in_ready;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [DNUM_W-1:0]    dnum_s0;
  logic [DNUM_W-1:0]    dnum_s1;
  logic                 bf_sel_s0;
  logic                 bf_sel_s1;
  logic [LOG2N-2:0]     w_idx;
  logic                 out_valid;
  logic [LOG2N-1:0]     out_idx;
`ifdef FFT_DELAY_CTRL_STAT_EN
  logic [FRAME_W-1:0]   frames_done;
`endif

  // Host / pipeline side.
  modport master (
    output start, frames, in_valid,
    input  in_ready, busy, done, err, dnum_s0, dnum_s1,
           bf_sel_s0, bf_sel_s1, w_idx, out_valid, out_idx
`ifdef FFT_DELAY_CTRL_STAT_EN
    , input frames_done
`endif
  );

  // Controller side.
  modport slave (
    input  start, frames, in_valid,
    output in_ready, busy, done, err, dnum_s0, dnum_s1,
           bf_sel_s0, bf_sel_s1, w_idx, out_valid, out_idx
`ifdef FFT_DELAY_CTRL_STAT_EN
    , output frames_done
`endif
  );

endinterface

// File: rtl/fft_delay_ctrl_tag_pipe.sv
// Fixed-depth shift register of {valid, index} tags following samples down the pipe.
module fft_tag_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_idx,
  output logic         out_valid,
  output logic [W-1:0] out_idx
);

  logic [DEPTH-1:0] v_q;
  logic [W-1:0]     idx_q [DEPTH];

  // Shift tags one slot per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) idx_q[i] <= '0;
    end else begin
      v_q[0]   <= in_valid;
      idx_q[0] <= in_idx;
      for (int i = 1; i < int'(DEPTH); i++) begin
        v_q[i]   <= v_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/fft_delay_ctrl.sv
// Sequencer for the 4-point radix-2 SDF FFT: run handshake, input framing,
// delay/butterfly/twiddle selects and output tags.
// Optional frames_done counter when FFT_DELAY_CTRL_STAT_EN is defined.
module fft_delay_ctrl
  import fft_delay_ctrl_pkg::*;
#(
  parameter int unsigned LOG2N   = 2,
  parameter int unsigned D_S0    = 2,
  parameter int unsigned D_S1    = 1,
  parameter int unsigned LAT_S0  = 3,
  parameter int unsigned LAT_S1  = 2,
  parameter int unsigned FRAME_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_delay_ctrl_if.slave bus
);

  localparam int unsigned N       = 1 << LOG2N;
  localparam int unsigned LAT_TOT = LAT_S0 + LAT_S1;
  localparam int unsigned FCNT_W  = 8;
  localparam int unsigned WIDX_W  = LOG2N - 1;

  fft_state_e           state_q;
  logic [LOG2N-1:0]     cnt_q;
  logic [FRAME_W-1:0]   fr_cnt_q;
  logic [FRAME_W-1:0]   frames_q;
  logic [FCNT_W-1:0]    fcnt_q;

  logic                 acc;
  logic                 last;
  logic [LOG2N-1:0]     tag_idx;
  logic                 t1_valid;
  logic [LOG2N-1:0]     t1_idx;
  logic                 to_valid;
  logic [LOG2N-1:0]     to_idx;

  // Sample accept, last-sample detect; idle tags carry index 0.
  assign acc     = bus.in_valid & bus.in_ready;
  assign last    = acc && (cnt_q == LOG2N'(N - 1)) && (fr_cnt_q == frames_q - FRAME_W'(1));
  assign tag_idx = acc ? cnt_q : '0;

  // Stage-1 tap; the final slot is the registered control below.
  fft_tag_pipe #(.DEPTH(LAT_S0 - 1), .W(LOG2N)) u_tap_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(acc), .in_idx(tag_idx),
    .out_valid(t1_valid), .out_idx(t1_idx)
  );

  // Output tap; the final slot is the registered out_valid/out_idx.
  fft_tag_pipe #(.DEPTH(LAT_TOT - 1), .W(LOG2N)) u_tap_out (
    .clk(clk), .rst_n(rst_n),
    .in_valid(acc), .in_idx(tag_idx),
    .out_valid(to_valid), .out_idx(to_idx)
  );

  // Run FSM with registered handshake, delay selects and stage-0 butterfly select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FFT_IDLE;
      cnt_q         <= '0;
      fr_cnt_q      <= '0;
      frames_q      <= '0;
      fcnt_q        <= '0;
      bus.in_ready  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.dnum_s0   <= '0;
      bus.dnum_s1   <= '0;
      bus.bf_sel_s0 <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.bf_sel_s0 <= acc & cnt_q[LOG2N-1];
      case (state_q)
        FFT_IDLE: begin
          if (bus.start) begin
            if (bus.frames != '0) begin
              frames_q    <= bus.frames;
              cnt_q       <= '0;
              fr_cnt_q    <= '0;
              bus.err     <= 1'b0;
              bus.busy    <= 1'b1;
              bus.dnum_s0 <= DNUM_W'(D_S0);
              bus.dnum_s1 <= DNUM_W'(D_S1);
              state_q     <= FFT_CFG;
            end else begin
              bus.done <= 1'b1;
            end
          end
        end
        FFT_CFG: begin
          bus.in_ready <= 1'b1;
          state_q      <= FFT_RUN;
        end
        FFT_RUN: begin
          if (!bus.in_valid) begin
            // Delay lines free-run, so any gap corrupts the frame.
            bus.err      <= 1'b1;
            bus.in_ready <= 1'b0;
            fcnt_q       <= '0;
            state_q      <= FFT_FLUSH;
          end else begin
            cnt_q <= cnt_q + LOG2N'(1);
            if (cnt_q == LOG2N'(N - 1)) fr_cnt_q <= fr_cnt_q + FRAME_W'(1);
            if (last) begin
              bus.in_ready <= 1'b0;
              fcnt_q       <= '0;
              state_q      <= FFT_FLUSH;
            end
          end
        end
        FFT_FLUSH: begin
          // done lands together with the last output tag.
          if (fcnt_q == FCNT_W'(LAT_TOT - 2)) begin
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            bus.dnum_s0 <= '0;
            bus.dnum_s1 <= '0;
            state_q     <= FFT_IDLE;
          end else begin
            fcnt_q <= fcnt_q + FCNT_W'(1);
          end
        end
        default: state_q <= FFT_IDLE;
      endcase
    end
  end

  // Stage-1 butterfly/twiddle selects and output tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bf_sel_s1 <= 1'b0;
      bus.w_idx     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
    end else begin
      bus.bf_sel_s1 <= t1_valid & t1_idx[0];
      bus.w_idx     <= (t1_valid & t1_idx[LOG2N-1]) ? WIDX_W'(t1_idx[0]) : '0;
      bus.out_valid <= to_valid;
      bus.out_idx   <= LOG2N'(bit_rev(8'(to_idx), LOG2N));
    end
  end

`ifdef FFT_DELAY_CTRL_STAT_EN
  // Saturating count of frames whose last bit-reversed sample was emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.frames_done <= '0;
    end else if (state_q == FFT_IDLE && bus.start && bus.frames != '0) begin
      bus.frames_done <= '0;
    end else if (to_valid && to_idx == LOG2N'(N - 1) && bus.frames_done != {FRAME_W{1'b1}}) begin
      bus.frames_done <= bus.frames_done + FRAME_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fft_delay_ctrl.sv
// Directed bench for fft_delay_ctrl: per-cycle vector table for a one-frame
// run plus sequences for reset abort, multi-frame, gap/err and zero-frame start.
module tb_fft_delay_ctrl;

  logic clk;
  logic rst_n;

  fft_delay_ctrl_if #(.LOG2N(2), .FRAME_W(8)) bus ();

  fft_delay_ctrl #(
    .LOG2N(2), .D_S0(2), .D_S1(1), .LAT_S0(3), .LAT_S1(2), .FRAME_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       rdy;
    logic       done;
    logic       err;
    logic [1:0] d0;
    logic [1:0] d1;
    logic       bf0;
    logic       bf1;
    logic       w;
    logic       ov;
    logic [1:0] idx;
  } outs_t;

  typedef struct {
    logic       start;
    logic [7:0] frames;
    logic       in_valid;
    outs_t      exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs [11];
  int rev4 [4];

  function automatic outs_t mk(int b, int r, int dn, int e, int d0, int d1,
                               int f0, int f1, int w, int ov, int idx);
    outs_t o;
    o.busy = 1'(b);  o.rdy = 1'(r);  o.done = 1'(dn); o.err = 1'(e);
    o.d0   = 2'(d0); o.d1  = 2'(d1); o.bf0  = 1'(f0); o.bf1 = 1'(f1);
    o.w    = 1'(w);  o.ov  = 1'(ov); o.idx  = 2'(idx);
    return o;
  endfunction

  function automatic outs_t get_outs();
    outs_t o;
    o.busy = bus.busy;      o.rdy = bus.in_ready;  o.done = bus.done;  o.err = bus.err;
    o.d0   = bus.dnum_s0;   o.d1  = bus.dnum_s1;   o.bf0  = bus.bf_sel_s0;
    o.bf1  = bus.bf_sel_s1; o.w   = bus.w_idx[0];  o.ov   = bus.out_valid;
    o.idx  = bus.out_idx;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input outs_t exp);
    outs_t act;
    act = get_outs();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One run from IDLE; gap_at = accepted-sample count at which in_valid drops (-1: none).
  task automatic run_frames(input logic [7:0] fr, input int gap_at,
                            output int accs, output int ovs, output int last_acc,
                            output int first_ov, output int last_ov, output int done_cyc);
    int cyc;
    bit gap_prev;
    bit finished;
    accs = 0; ovs = 0; last_acc = -1; first_ov = -1; last_ov = -1; done_cyc = -1;
    cyc = 0; gap_prev = 0; finished = 0;
    bus.start = 1'b1; bus.frames = fr; bus.in_valid = 1'b1;
    while (cyc < 200 && !finished) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      if (cyc == 1) begin
        check("start_busy_err", 32'({bus.busy, bus.err}), 32'b10);
`ifdef FFT_DELAY_CTRL_STAT_EN
        check("frames_done_clear", 32'(bus.frames_done), 32'd0);
`endif
      end
      if (gap_prev) begin
        check("gap_err_rdy", 32'({bus.err, bus.in_ready}), 32'b10);
        gap_prev = 0;
      end
      if (bus.out_valid) begin
        check("out_idx", 32'(bus.out_idx), 32'(rev4[ovs % 4]));
        if (first_ov < 0) first_ov = cyc;
        last_ov = cyc;
        ovs++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        finished = 1;
      end else if (bus.in_ready) begin
        if (accs == gap_at) begin
          bus.in_valid = 1'b0;
          gap_prev = 1;
        end else begin
          accs++;
          last_acc = cyc;
        end
      end
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got no done expected done within 200 cycles");
    end
  endtask

  initial begin
    int accs, ovs, last_acc, first_ov, last_ov, done_cyc, n;
    bit ok;

    rev4[0] = 0; rev4[1] = 2; rev4[2] = 1; rev4[3] = 3;

    // start=1 frames=1 run, start re-issued while busy on row 3 (frames=5, ignored)
    vecs[0]  = '{1'b1, 8'd1, 1'b1, mk(1,0,0,0,2,1,0,0,0,0,0)};
    vecs[1]  = '{1'b0, 8'd0, 1'b1, mk(1,1,0,0,2,1,0,0,0,0,0)};
    vecs[2]  = '{1'b0, 8'd0, 1'b1, mk(1,1,0,0,2,1,0,0,0,0,0)};
    vecs[3]  = '{1'b1, 8'd5, 1'b1, mk(1,1,0,0,2,1,0,0,0,0,0)};
    vecs[4]  = '{1'b0, 8'd0, 1'b1, mk(1,1,0,0,2,1,1,0,0,0,0)};
    vecs[5]  = '{1'b0, 8'd0, 1'b1, mk(1,0,0,0,2,1,1,1,0,0,0)};
    vecs[6]  = '{1'b0, 8'd0, 1'b1, mk(1,0,0,0,2,1,0,0,0,1,0)};
    vecs[7]  = '{1'b0, 8'd0, 1'b1, mk(1,0,0,0,2,1,0,1,1,1,2)};
    vecs[8]  = '{1'b0, 8'd0, 1'b1, mk(1,0,0,0,2,1,0,0,0,1,1)};
    vecs[9]  = '{1'b0, 8'd0, 1'b1, mk(0,0,1,0,0,0,0,0,0,1,3)};
    vecs[10] = '{1'b0, 8'd0, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0)};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.frames = 8'd0; bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset_outs", mk(0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset during RUN after 3 accepted samples.
    bus.start = 1'b1; bus.frames = 8'd1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (bus.in_ready) n++;
      @(posedge clk); #1;
    end
    check("midrst_accepts", 32'(n), 32'd3);
    rst_n = 1'b0;
    #1;
    check_outs("midrst_outs_now", mk(0,0,0,0,0,0,0,0,0,0,0));
    ok = 1;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) ok = 0;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) ok = 0;
    end
    check("midrst_no_done_idle", 32'(ok), 32'd1);

    // Vector table: single frame.
    for (int j = 0; j < 11; j++) begin
      bus.start    = vecs[j].start;
      bus.frames   = vecs[j].frames;
      bus.in_valid = vecs[j].in_valid;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", j), vecs[j].exp);
    end
    bus.start = 1'b0;

    // Three contiguous frames.
    run_frames(8'd3, -1, accs, ovs, last_acc, first_ov, last_ov, done_cyc);
    check("f3_accepts", 32'(accs), 32'd12);
    check("f3_out_count", 32'(ovs), 32'd12);
    check("f3_out_span", 32'(last_ov - first_ov), 32'd11);
    check("f3_first_out", 32'(first_ov), 32'd7);
    check("f3_done_lat", 32'(done_cyc - last_acc), 32'd5);
    check("f3_idle_dnum", 32'({bus.busy, bus.dnum_s0, bus.dnum_s1}), 32'd0);
`ifdef FFT_DELAY_CTRL_STAT_EN
    check("f3_frames_done", 32'(bus.frames_done), 32'd3);
`endif

    // Two frames with a gap at sample 6.
    run_frames(8'd2, 6, accs, ovs, last_acc, first_ov, last_ov, done_cyc);
    check("gap_accepts", 32'(accs), 32'd6);
    check("gap_out_count", 32'(ovs), 32'd6);
    check("gap_done_cyc", 32'(done_cyc), 32'd13);
`ifdef FFT_DELAY_CTRL_STAT_EN
    check("gap_frames_done", 32'(bus.frames_done), 32'd1);
`endif
    @(posedge clk); #1;
    check("err_sticky_idle", 32'({bus.err, bus.busy}), 32'b10);

    // Next start clears err (checked at cycle 1 inside the run).
    run_frames(8'd1, -1, accs, ovs, last_acc, first_ov, last_ov, done_cyc);
    check("f1_accepts", 32'(accs), 32'd4);
    check("f1_done_lat", 32'(done_cyc - last_acc), 32'd5);
    check("f1_err_after", 32'(bus.err), 32'd0);

    // Zero-frame start.
    bus.start = 1'b1; bus.frames = 8'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("f0_done_pulse", 32'({bus.done, bus.busy}), 32'b10);
    ok = 1;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) ok = 0;
    end
    check("f0_quiet", 32'(ok), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_delay_ctrl.md
Name: fft_delay_ctrl

Overview:
- Sequencer for the 4-point radix-2 single-path delay-feedback FFT pipeline.
- Drives the `dnum` select of each stage's delay line, the butterfly add/pass select, the twiddle index and output-valid/index tags.
- Runs a start/busy/done handshake toward the host and frames a contiguous input sample stream.
- Sits between the host/input interface and the two FFT stages (delay + butterfly + twiddle multiply).

Parameters:
- LOG2N, 2, log2 of FFT points; N = 1<<LOG2N.
- D_S0, 2, delay select driven to stage 0 during RUN (1..3).
- D_S1, 1, delay select driven to stage 1 during RUN (1..3).
- LAT_S0, 3, stage-0 latency in cycles (delay + butterfly register).
- LAT_S1, 2, stage-1 latency in cycles.
- FRAME_W, 8, width of frame count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run.
- frames  in  FRAME_W  number of N-point frames; sampled on accepted start.
- in_valid  in  1  input sample present this cycle.
- in_ready  out  1  controller accepting samples.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- err  out  1  sticky; input gap mid-run.
- dnum_s0  out  `DNumBus  delay select, stage 0.
- dnum_s1  out  `DNumBus  delay select, stage 1.
- bf_sel_s0  out  1  stage-0 butterfly: 1 = compute, 0 = pass/fill.
- bf_sel_s1  out  1  stage-1 butterfly select.
- w_idx  out  LOG2N-1  twiddle index for the stage-0 output.
- out_valid  out  1  pipeline output sample valid.
- out_idx  out  LOG2N  frequency index of the output sample (bit-reversed order).

Behaviour:
- Reset (async, rst_n low):
  - state IDLE.
  - All outputs 0; dnum 0 makes the delay blocks emit zero.
  - All counters cleared. Mid-run reset aborts immediately with no done pulse.
- IDLE:
  - start with frames != 0: latch frames, clear err, go CFG.
  - start with frames == 0: done pulses next cycle, busy stays 0.
- CFG (1 cycle):
  - busy = 1; dnum_s0 = D_S0, dnum_s1 = D_S1 (held until return to IDLE).
  - Next state RUN.
- RUN:
  - in_ready = 1.
  - Sample counter cnt (LOG2N bits) increments on in_valid & in_ready and wraps N-1 -> 0; frame counter increments on each wrap.
  - The delay lines free-run, so input must be contiguous. in_valid = 0 in any RUN cycle sets err and goes FLUSH.
  - Last sample of last frame accepted: go FLUSH next cycle.
- Stage-0 control: bf_sel_s0 = cnt[LOG2N-1] for the sample entering stage 0.
- Stage-1 control:
  - A valid+index shift pipeline delays (valid, cnt) by LAT_S0 to give pos1.
  - bf_sel_s1 = pos1[0] & valid1.
  - w_idx = pos1[LOG2N-1] ? pos1[0] : 0.
- Output tags:
  - (valid, cnt) delayed by LAT_S0 + LAT_S1 = 5 cycles gives out_valid.
  - out_idx = bit-reverse of the delayed cnt.
  - Gap-aborted samples are tagged out_valid = 0.
- FLUSH:
  - in_ready = 0; wait until the tag pipeline is empty (LAT_S0 + LAT_S1 cycles).
  - Then done = 1 for one cycle; dnum_s0/s1, bf_sel and w_idx return to 0; go IDLE.
- start while busy: ignored.
- err stays set until the next accepted start.

Optional Feature:
- Macro: FFT_DELAY_CTRL_STAT_EN.
- When defined: adds output frames_done [FRAME_W-1:0], the count of frames fully emitted (out_valid with out_idx of the last bit-reversed index). It saturates at max, clears on accepted start, and keeps its value in IDLE.
- When undefined: the port and counter are absent, and the remaining behaviour is identical.

Decomposition:
- std_define.h:
  - `FftStateBus` and state encodings `FFT_IDLE`, `FFT_CFG`, `FFT_RUN`, `FFT_FLUSH`.
  - `FftFrameBus`.
  - Existing `DNumBus` reused.
- Sub-module fft_tag_pipe: parameterised-depth shift register of {valid, index}, instantiated for the stage-1 tap and the output tap.

Test Plan:
- Reset mid-RUN (assert rst_n=0 after 3 samples) -> all outputs 0 the same cycle, no done, IDLE after release.
- start, frames=1, 4 contiguous samples:
  - dnum_s0=2 and dnum_s1=1 from the cycle after start.
  - bf_sel_s0 = 0,0,1,1.
  - out_valid high on cycles 5-8 after the first accept, with out_idx = 0,2,1,3.
  - done exactly once, then dnum = 0.
- start, frames=3, 12 contiguous samples -> cnt wraps 3 times; 12 consecutive out_valid; done 5 cycles after the last accept.
- frames=2, in_valid low at sample 6 -> err = 1, in_ready drops, done after flush, err cleared by next start.
- start with frames=0 -> done pulse next cycle, busy never asserted; start during busy -> no effect on frame count.
- FFT_DELAY_CTRL_STAT_EN defined, frames=3 run -> frames_done = 3 after done; next start clears it to 0.
